rx_buffer_ctrl: RTL and testbench

Receive-side buffer controller for the UART path: it collects each byte the serial receiver announces and stores it in an external single-port RAM organised as a circular FIFO. It also tracks complete messages terminated by an end-of-message character and serves bytes to a downstream consumer. It sits between the receiver's byte-strobe/data outputs and the message-processing logic, and arbitrates the single RAM port between receiver writes and consumer reads.

---
 rtl/rx_buffer_ctrl.sv | 156 +++++++++++++++
 tb/tb_rx_buffer_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_buffer_ctrl.sv
// UART receive buffer controller: circular FIFO in an external single-port RAM,
// with end-of-message tracking and a registered consumer read path.
module rx_buffer_ctrl #(
  parameter int unsigned ADDR_W   = 4,
  parameter logic [7:0]  EOM_CHAR = 8'h0D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              charRecived,
  input  logic [7:0]        dataToMem,
  input  logic              rdReq,
  input  logic              clrOvf,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWrEn,
  output logic [7:0]        memWrData,
  output logic              memRdEn,
  input  logic [7:0]        memRdData,
  output logic [7:0]        rdData,
  output logic              rdValid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   msgCount,
  output logic              msgReady,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WR, RD, RDW} state_t;

  state_t            state;
  logic [1:0]        syncR;
  logic              syncDly;
  logic              byteEvt;
  logic              pend;
  logic [7:0]        holdData;
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic              dropNow_c;
  logic              fullDrop_c;

  // A new byte while one is still waiting is lost; the slot frees on WR exit.
  assign dropNow_c  = byteEvt & pend & (state != WR);
  assign fullDrop_c = (state == WR) & ~memWrEn;

  // Strobe synchronizer and single-shot rising-edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncR   <= 2'b00;
      syncDly <= 1'b0;
      byteEvt <= 1'b0;
    end else begin
      syncR   <= {syncR[0], charRecived};
      syncDly <= syncR[1];
      byteEvt <= syncR[1] & ~syncDly;
    end
  end

  // Holding register for the byte awaiting a RAM write slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= 1'b0;
      holdData <= 8'h00;
    end else if (byteEvt && !dropNow_c) begin
      pend     <= 1'b1;
      holdData <= dataToMem;
    end else if (state == WR) begin
      pend     <= 1'b0;
    end
  end

  // Sticky overflow; a drop in the same cycle beats the clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (dropNow_c || fullDrop_c) begin
      overflow <= 1'b1;
    end else if (clrOvf) begin
      overflow <= 1'b0;
    end
  end

  // RAM port arbitration FSM with registered outputs and occupancy tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      memAddr   <= '0;
      memWrEn   <= 1'b0;
      memWrData <= 8'h00;
      memRdEn   <= 1'b0;
      rdData    <= 8'h00;
      rdValid   <= 1'b0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      msgCount  <= '0;
      msgReady  <= 1'b0;
    end else begin
      memWrEn <= 1'b0;
      memRdEn <= 1'b0;
      rdValid <= 1'b0;
      case (state)
        IDLE: begin
          if (pend) begin
            state <= WR;
            if (!full) begin
              memWrEn   <= 1'b1;
              memAddr   <= wrPtr;
              memWrData <= holdData;
            end
          end else if (rdReq && !empty) begin
            state   <= RD;
            memRdEn <= 1'b1;
            memAddr <= rdPtr;
          end
        end
        WR: begin
          state <= IDLE;
          if (memWrEn) begin
            wrPtr <= wrPtr + ADDR_W'(1);
            count <= count + CNT_W'(1);
            full  <= (count + CNT_W'(1)) == FULL_CNT;
            empty <= 1'b0;
            if (memWrData == EOM_CHAR) begin
              msgCount <= msgCount + CNT_W'(1);
              msgReady <= 1'b1;
            end
          end
        end
        RD: begin
          state <= RDW;
        end
        RDW: begin
          state   <= IDLE;
          rdData  <= memRdData;
          rdValid <= 1'b1;
          rdPtr   <= rdPtr + ADDR_W'(1);
          count   <= count - CNT_W'(1);
          full    <= 1'b0;
          empty   <= count == CNT_W'(1);
          if (memRdData == EOM_CHAR && msgCount != '0) begin
            msgCount <= msgCount - CNT_W'(1);
            msgReady <= msgCount != CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// Directed bench for rx_buffer_ctrl with a behavioural single-port RAM.
module tb_rx_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       charRecived;
  logic [7:0] dataToMem;
  logic       rdReq;
  logic       clrOvf;
  logic [3:0] memAddr;
  logic       memWrEn;
  logic [7:0] memWrData;
  logic       memRdEn;
  logic [7:0] memRdData = 8'h00;
  logic [7:0] rdData;
  logic       rdValid;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic [4:0] msgCount;
  logic       msgReady;
  logic       overflow;

  rx_buffer_ctrl #(.ADDR_W(4), .EOM_CHAR(8'h0D)) dut (
    .clk(clk), .rst(rst), .charRecived(charRecived), .dataToMem(dataToMem),
    .rdReq(rdReq), .clrOvf(clrOvf), .memAddr(memAddr), .memWrEn(memWrEn),
    .memWrData(memWrData), .memRdEn(memRdEn), .memRdData(memRdData),
    .rdData(rdData), .rdValid(rdValid), .count(count), .full(full),
    .empty(empty), .msgCount(msgCount), .msgReady(msgReady), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic [7:0] din;
    logic [3:0] expAddr;
    logic [4:0] expCount;
    logic [4:0] expMsg;
  } vec_t;

  logic [7:0] ram [16];
  wr_t        wrLog[$];
  logic [7:0] rdLog[$];
  int         rdCyc[$];
  int         rdEnCnt = 0;
  int         cyc = 0;
  int         nChecks = 0;
  int         nFail = 0;
  int         rdEnBase;
  vec_t       vec[3];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (memWrEn) ram[memAddr] <= memWrData;
    if (memRdEn) memRdData <= ram[memAddr];
  end

  always @(negedge clk) begin
    if (memWrEn) wrLog.push_back('{a: memAddr, d: memWrData});
    if (rdValid) begin
      rdLog.push_back(rdData);
      rdCyc.push_back(cyc);
    end
    if (memRdEn) rdEnCnt = rdEnCnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearLogs();
    wrLog.delete();
    rdLog.delete();
    rdCyc.delete();
    rdEnBase = rdEnCnt;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    rdReq = 1'b0;
    charRecived = 1'b0;
    clrOvf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clearLogs();
  endtask

  task automatic strobe(input logic [7:0] d, input int width, input int gap);
    @(posedge clk);
    #1;
    dataToMem = d;
    charRecived = 1'b1;
    repeat (width) @(posedge clk);
    #1;
    charRecived = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic waitReads(input int n, input int budget);
    int k = 0;
    while (rdLog.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    chk("reads_done", 32'(rdLog.size() >= n), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_memAddr"}, 32'(memAddr), 32'd0);
    chk({tag, "_memWrEn"}, 32'(memWrEn), 32'd0);
    chk({tag, "_memWrData"}, 32'(memWrData), 32'd0);
    chk({tag, "_memRdEn"}, 32'(memRdEn), 32'd0);
    chk({tag, "_rdData"}, 32'(rdData), 32'd0);
    chk({tag, "_rdValid"}, 32'(rdValid), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_msgCount"}, 32'(msgCount), 32'd0);
    chk({tag, "_msgReady"}, 32'(msgReady), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    vec[0] = '{din: 8'h41, expAddr: 4'd0, expCount: 5'd1, expMsg: 5'd0};
    vec[1] = '{din: 8'h42, expAddr: 4'd1, expCount: 5'd2, expMsg: 5'd0};
    vec[2] = '{din: 8'h0D, expAddr: 4'd2, expCount: 5'd3, expMsg: 5'd1};

    rst = 1'b0;
    charRecived = 1'b0;
    dataToMem = 8'h00;
    rdReq = 1'b0;
    clrOvf = 1'b0;
    rdEnBase = 0;
    repeat (3) @(negedge clk);
    checkResetOutputs("rst_in");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkResetOutputs("rst_out");
    clearLogs();

    // Three framed bytes, the last one terminating a message
    for (int i = 0; i < 3; i++) begin
      strobe(vec[i].din, 16, 200);
      @(negedge clk);
      chk("wr_num", 32'(wrLog.size()), 32'(i + 1));
      if (wrLog.size() == i + 1) begin
        chk("wr_addr", 32'(wrLog[i].a), 32'(vec[i].expAddr));
        chk("wr_data", 32'(wrLog[i].d), 32'(vec[i].din));
      end
      chk("wr_count", 32'(count), 32'(vec[i].expCount));
      chk("wr_msgCount", 32'(msgCount), 32'(vec[i].expMsg));
    end
    chk("t1_overflow", 32'(overflow), 32'd0);
    chk("t1_msgReady", 32'(msgReady), 32'd1);

    // Back-to-back reads with rdReq held
    @(posedge clk);
    #1 rdReq = 1'b1;
    waitReads(3, 100);
    if (rdLog.size() >= 3) begin
      for (int i = 0; i < 3; i++) chk("rd_data", 32'(rdLog[i]), 32'(vec[i].din));
      chk("rd_spacing1", 32'(rdCyc[1] - rdCyc[0]), 32'd3);
      chk("rd_spacing2", 32'(rdCyc[2] - rdCyc[1]), 32'd3);
    end
    repeat (20) @(negedge clk);
    chk("rd_no_extra", 32'(rdEnCnt - rdEnBase), 32'd3);
    chk("rd_empty", 32'(empty), 32'd1);
    chk("rd_msgCount", 32'(msgCount), 32'd0);
    chk("rd_msgReady", 32'(msgReady), 32'd0);
    rdReq = 1'b0;

    // Fill to capacity, drop the 17th byte, then clear overflow
    doReset();
    for (int i = 0; i < 17; i++) strobe(8'(8'h80 + i), 4, 12);
    repeat (4) @(negedge clk);
    chk("ovf_wr_num", 32'(wrLog.size()), 32'd16);
    for (int i = 0; i < 16 && i < wrLog.size(); i++)
      chk("ovf_wr_addr", 32'(wrLog[i].a), 32'(i));
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_set", 32'(overflow), 32'd1);
    clrOvf = 1'b1;
    @(negedge clk);
    clrOvf = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Pointer wrap: write 12, read 12, write 8, read 8
    doReset();
    for (int i = 0; i < 12; i++) strobe(8'(8'h20 + i), 4, 12);
    rdReq = 1'b1;
    waitReads(12, 200);
    rdReq = 1'b0;
    repeat (3) @(negedge clk);
    chk("wrap_empty", 32'(empty), 32'd1);
    clearLogs();
    for (int i = 0; i < 8; i++) strobe(8'(8'h60 + i), 4, 12);
    chk("wrap_wr_num", 32'(wrLog.size()), 32'd8);
    for (int i = 0; i < 8 && i < wrLog.size(); i++) begin
      chk("wrap_wr_addr", 32'(wrLog[i].a), 32'((12 + i) % 16));
      chk("wrap_wr_data", 32'(wrLog[i].d), 32'(8'h60 + i));
    end
    rdReq = 1'b1;
    waitReads(8, 200);
    rdReq = 1'b0;
    for (int i = 0; i < 8 && i < rdLog.size(); i++)
      chk("wrap_rd_data", 32'(rdLog[i]), 32'(8'h60 + i));
    repeat (3) @(negedge clk);
    chk("wrap_count", 32'(count), 32'd0);

    // Byte strobe arriving while reads are in progress
    doReset();
    strobe(8'h11, 4, 12);
    strobe(8'h22, 4, 12);
    clearLogs();
    @(posedge clk);
    #1;
    rdReq = 1'b1;
    dataToMem = 8'h33;
    charRecived = 1'b1;
    repeat (16) @(posedge clk);
    #1 charRecived = 1'b0;
    waitReads(3, 100);
    rdReq = 1'b0;
    if (rdLog.size() >= 3) begin
      chk("coll_rd0", 32'(rdLog[0]), 32'h11);
      chk("coll_rd1", 32'(rdLog[1]), 32'h22);
      chk("coll_rd2", 32'(rdLog[2]), 32'h33);
    end
    chk("coll_wr_num", 32'(wrLog.size()), 32'd1);
    if (wrLog.size() >= 1) begin
      chk("coll_wr_addr", 32'(wrLog[0].a), 32'd2);
      chk("coll_wr_data", 32'(wrLog[0].d), 32'h33);
    end
    chk("coll_overflow", 32'(overflow), 32'd0);

    // Reset asserted while a read is in its RDW cycle
    doReset();
    strobe(8'h77, 4, 12);
    chk("abort_count_pre", 32'(count), 32'd1);
    clearLogs();
    @(posedge clk);
    #1 rdReq = 1'b1;
    begin
      int k = 0;
      while (!memRdEn && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("abort_rd_seen", 32'(memRdEn), 32'd1);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    rdReq = 1'b0;
    #1;
    checkResetOutputs("abort_async");
    repeat (2) @(negedge clk);
    checkResetOutputs("abort_hold");
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_rdValid", 32'(rdLog.size()), 32'd0);
    chk("abort_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
